// File: rtl/bp_me_lite_to_stream_buffered.sv
// bp_me_lite_to_stream_buffered
//
// Converts BP Lite memory messages into BP Stream beats. A Lite message is
// one header plus full-width data. A Stream message is the same header,
// with the address rewritten for each beat, plus one narrow data slice per
// beat. Up to buffer_els_p whole messages are queued, so the Lite master is
// not stalled while an earlier message drains.
//
// Optional feature (compile-time macro BP_ME_LITE_TO_STREAM_WRAP_EN):
//   defined   - beats are emitted critical-word-first and wrap inside the
//               aligned block of count*out_bytes bytes
//   undefined - beats are emitted in linear order from the message address
//
// Processor-config widths are exposed as plain parameters
// (paddr_width_p, payload_width_p).
//
// Header layout, LSB first:
//   msg_type[3:0] | addr[paddr_width_p-1:0] | size[2:0] | payload
// Lite message layout: {data[in_data_width_p-1:0], header}
//
// Ports:
//   clk_i         in   clock
//   reset_i       in   synchronous, active-high reset
//   mem_i         in   Lite message (header + data)
//   mem_v_i       in   Lite message valid
//   mem_ready_o   out  buffer can accept a message (registered not-full)
//   mem_header_o  out  per-beat header carrying the beat address
//   mem_data_o    out  beat data
//   mem_v_o       out  beat valid
//   mem_yumi_i    in   beat consumed (only while mem_v_o)
//   mem_last_o    out  current beat is the last beat of its message
//   mem_lock_o    out  message in progress, downstream must not interleave
//
// stream_words_lp (in/out width ratio) must be a power of two when wrapping
// is enabled, because the wrap arithmetic works by masking.
module bp_me_lite_to_stream_buffered
    #(parameter int paddr_width_p    = 40
    , parameter int payload_width_p  = 16
    , parameter int in_data_width_p  = 512
    , parameter int out_data_width_p = 64
    , parameter int master_p         = 0
    , parameter int buffer_els_p     = 2
    , localparam int out_mem_msg_header_width_lp = payload_width_p + 3 + paddr_width_p + 4
    , localparam int in_mem_msg_width_lp         = in_data_width_p + out_mem_msg_header_width_lp
    )
    (input  logic                                   clk_i
    , input  logic                                   reset_i
    , input  logic [in_mem_msg_width_lp-1:0]         mem_i
    , input  logic                                   mem_v_i
    , output logic                                   mem_ready_o
    , output logic [out_mem_msg_header_width_lp-1:0] mem_header_o
    , output logic [out_data_width_p-1:0]            mem_data_o
    , output logic                                   mem_v_o
    , input  logic                                   mem_yumi_i
    , output logic                                   mem_last_o
    , output logic                                   mem_lock_o
    );

    localparam int header_width_lp = out_mem_msg_header_width_lp;
    localparam int stream_words_lp = in_data_width_p / out_data_width_p;
    localparam int out_bytes_lp    = out_data_width_p / 8;
    localparam int byte_sel_lp     = $clog2(out_bytes_lp);
    localparam int beat_w_lp       = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
    localparam int ptr_w_lp        = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
    localparam int occ_w_lp        = $clog2(buffer_els_p + 1);
    localparam int addr_lsb_lp     = 4;
    localparam int size_lsb_lp     = 4 + paddr_width_p;

    localparam logic [3:0] e_mem_msg_wr    = 4'd1;
    localparam logic [3:0] e_mem_msg_uc_wr = 4'd3;

    // Incoming message split and beat-count computation
    logic [header_width_lp-1:0] in_header;
    logic [in_data_width_p-1:0] in_data;
    logic [3:0]                 in_type;
    logic [2:0]                 in_size;
    logic                       in_is_wr;
    logic [31:0]                in_words;
    logic [beat_w_lp-1:0]       in_last_idx;

    assign in_header = mem_i[header_width_lp-1:0];
    assign in_data   = mem_i[header_width_lp +: in_data_width_p];
    assign in_type   = in_header[3:0];
    assign in_size   = in_header[size_lsb_lp +: 3];
    assign in_is_wr  = (in_type == e_mem_msg_wr) || (in_type == e_mem_msg_uc_wr);

    // The stored value is count-1 so a full stream_words_lp count fits in
    // the beat counter width.
    always_comb begin
        in_words = 32'd1;
        if ((master_p != 0) == in_is_wr) begin
            if (int'(in_size) > byte_sel_lp) begin
                in_words = 32'd1 << (int'(in_size) - byte_sel_lp);
            end
            if (in_words > stream_words_lp) begin
                in_words = stream_words_lp;
            end
        end
        in_last_idx = beat_w_lp'(in_words - 32'd1);
    end

    // Message buffer
    logic [header_width_lp-1:0] hdr_mem  [buffer_els_p];
    logic [in_data_width_p-1:0] data_mem [buffer_els_p];
    logic [beat_w_lp-1:0]       last_mem [buffer_els_p];

    logic [ptr_w_lp-1:0]  wptr;
    logic [ptr_w_lp-1:0]  rptr;
    logic [occ_w_lp-1:0]  occ;
    logic [occ_w_lp-1:0]  occ_next;
    logic                 ready_r;
    logic [beat_w_lp-1:0] k;

    logic enq;
    logic deq;
    logic head_last;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        if (p == ptr_w_lp'(buffer_els_p - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign enq       = mem_v_i & ready_r;
    assign mem_v_o   = (occ != '0);
    assign head_last = mem_v_o & (k == last_mem[rptr]);
    assign deq       = mem_yumi_i & head_last;

    always_comb begin
        occ_next = occ;
        if (enq & ~deq) begin
            occ_next = occ + 1'b1;
        end else if (deq & ~enq) begin
            occ_next = occ - 1'b1;
        end
    end

    // Ready is registered from the post-update occupancy, so a dequeue from
    // a full buffer only re-opens the input on the following cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            ready_r <= 1'b0;
            k       <= '0;
        end else begin
            occ     <= occ_next;
            ready_r <= (occ_next != occ_w_lp'(buffer_els_p));
            if (enq) begin
                wptr <= ptr_inc(wptr);
            end
            if (deq) begin
                rptr <= ptr_inc(rptr);
                k    <= '0;
            end else if (mem_yumi_i & mem_v_o) begin
                k <= k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            hdr_mem[wptr]  <= in_header;
            data_mem[wptr] <= in_data;
            last_mem[wptr] <= in_last_idx;
        end
    end

    // Head entry and beat selection
    logic [header_width_lp-1:0] head_hdr;
    logic [in_data_width_p-1:0] head_data;
    logic [beat_w_lp-1:0]       head_last_idx;
    logic [paddr_width_p-1:0]   head_addr;
    logic [beat_w_lp-1:0]       beat_idx;
    logic [paddr_width_p-1:0]   beat_addr;

    assign head_hdr      = hdr_mem[rptr];
    assign head_data     = data_mem[rptr];
    assign head_last_idx = last_mem[rptr];
    assign head_addr     = head_hdr[addr_lsb_lp +: paddr_width_p];

`ifdef BP_ME_LITE_TO_STREAM_WRAP_EN
    logic [beat_w_lp-1:0]     start_idx;
    logic [paddr_width_p-1:0] low_mask;
    logic [paddr_width_p-1:0] span_mask;

    // count is a power of two, so count-1 masks both the start index and
    // the modulo of the running index.
    assign start_idx = head_addr[byte_sel_lp +: beat_w_lp] & head_last_idx;
    assign beat_idx  = (start_idx + k) & head_last_idx;
    assign low_mask  = paddr_width_p'(out_bytes_lp - 1);
    assign span_mask = (paddr_width_p'(head_last_idx) << byte_sel_lp) | low_mask;
    // Sub-beat byte offset survives on the critical (first) beat only.
    assign beat_addr = (head_addr & ~span_mask)
                     | (paddr_width_p'(beat_idx) << byte_sel_lp)
                     | ((k == '0) ? (head_addr & low_mask) : '0);
`else
    assign beat_idx  = k;
    assign beat_addr = head_addr + (paddr_width_p'(k) << byte_sel_lp);
`endif

    generate
        if (stream_words_lp == 1) begin : g_one_word
            assign mem_data_o = head_data;
        end else begin : g_multi_word
            logic [out_data_width_p-1:0] words [stream_words_lp];
            for (genvar i = 0; i < stream_words_lp; i++) begin : g_split
                assign words[i] = head_data[i*out_data_width_p +: out_data_width_p];
            end
            assign mem_data_o = words[beat_idx];
        end
    endgenerate

    always_comb begin
        mem_header_o = head_hdr;
        mem_header_o[addr_lsb_lp +: paddr_width_p] = beat_addr;
    end

    assign mem_last_o  = head_last;
    assign mem_lock_o  = mem_v_o;
    assign mem_ready_o = ready_r;

endmodule

// File: tb/tb_bp_me_lite_to_stream_buffered.sv
`timescale 1ns/1ps
module tb_bp_me_lite_to_stream_buffered;

    localparam int PADDR = 40;
    localparam int PAY   = 16;
    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int HDR_W = PAY + 3 + PADDR + 4;
    localparam int MSG_W = IN_W + HDR_W;
    localparam int B_MSG_W = 64 + HDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                                 input logic [PADDR-1:0] a, input logic [PAY-1:0] p);
        return {p, sz, a, t};
    endfunction

    function automatic logic [MSG_W-1:0] mk_msg(input logic [3:0] t, input logic [2:0] sz,
                                                input logic [PADDR-1:0] a, input logic [IN_W-1:0] d);
        return {d, mk_hdr(t, sz, a, 16'h5A5A)};
    endfunction

    function automatic logic [IN_W-1:0] rand_data();
        logic [IN_W-1:0] d;
        for (int i = 0; i < IN_W/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [MSG_W-1:0] rand_msg();
        logic [PADDR-1:0] a;
        a = {$urandom, $urandom} & {PADDR{1'b1}};
        if ($urandom_range(0, 3) == 0) a = 40'hFF_FFFF_FF00 | PADDR'($urandom_range(0, 255));
        return {rand_data(), mk_hdr(4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, 16'($urandom))};
    endfunction

    // Two 512->64 instances: index 0 is command direction (2 entries),
    // index 1 is response direction (3 entries).
    logic [MSG_W-1:0] m_i     [2];
    logic             v_i     [2];
    logic             yumi    [2];
    logic             ready_o [2];
    logic [HDR_W-1:0] hdr_o   [2];
    logic [OUT_W-1:0] data_o  [2];
    logic             v_o     [2];
    logic             last_o  [2];
    logic             lock_o  [2];

    typedef struct {
        logic [HDR_W-1:0] hdr;
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    for (genvar g = 0; g < 2; g++) begin : gen_h
        localparam int MASTER_G = (g == 0) ? 1 : 0;
        localparam int ELS_G    = (g == 0) ? 2 : 3;

        bp_me_lite_to_stream_buffered #(
            .paddr_width_p(PADDR), .payload_width_p(PAY),
            .in_data_width_p(IN_W), .out_data_width_p(OUT_W),
            .master_p(MASTER_G), .buffer_els_p(ELS_G)
        ) dut (
            .clk_i(clk), .reset_i(reset),
            .mem_i(m_i[g]), .mem_v_i(v_i[g]), .mem_ready_o(ready_o[g]),
            .mem_header_o(hdr_o[g]), .mem_data_o(data_o[g]), .mem_v_o(v_o[g]),
            .mem_yumi_i(yumi[g]), .mem_last_o(last_o[g]), .mem_lock_o(lock_o[g])
        );

        // Reference: a queue of every beat still owed, plus a count of whole
        // messages held, from which readiness follows directly.
        beat_t q[$];
        int    msgs;
        logic  ready_m;

        always @(posedge clk) begin : model
            logic [HDR_W-1:0] h;
            logic [IN_W-1:0]  d;
            longint unsigned  a, ba, cnt, s, j;
            logic             is_wr;
            beat_t            nb, ob;
            if (reset) begin
                q.delete();
                msgs = 0;
                ready_m = 1'b0;
            end else begin
                if (yumi[g] && q.size() > 0) begin
                    ob = q.pop_front();
                    if (ob.last) msgs--;
                end
                if (v_i[g] && ready_m) begin
                    h = m_i[g][HDR_W-1:0];
                    d = m_i[g][MSG_W-1 -: IN_W];
                    a = longint'(h[4 +: PADDR]);
                    is_wr = (h[3:0] == 4'd1) || (h[3:0] == 4'd3);
                    if ((MASTER_G != 0) != is_wr) cnt = 1;
                    else begin
                        cnt = (longint'(1) << h[PADDR+4 +: 3]) / 8;
                        if (cnt < 1) cnt = 1;
                        if (cnt > 8) cnt = 8;
                    end
                    for (int b = 0; b < int'(cnt); b++) begin
`ifdef BP_ME_LITE_TO_STREAM_WRAP_EN
                        s  = (a / 8) % cnt;
                        j  = (s + longint'(b)) % cnt;
                        ba = a - (a % (cnt * 8)) + j * 8 + ((b == 0) ? (a % 8) : 0);
`else
                        j  = longint'(b);
                        ba = a + j * 8;
`endif
                        nb.hdr = h;
                        nb.hdr[4 +: PADDR] = PADDR'(ba);
                        nb.data = OUT_W'(d >> (j * OUT_W));
                        nb.last = (longint'(b) == cnt - 1);
                        q.push_back(nb);
                    end
                    msgs++;
                end
                ready_m = (msgs < ELS_G);
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("dut%0d_ready", g), 64'(ready_o[g]), 64'(ready_m));
                check($sformatf("dut%0d_valid", g), 64'(v_o[g]), 64'(q.size() > 0));
                check($sformatf("dut%0d_lock", g), 64'(lock_o[g]), 64'(q.size() > 0));
                if (q.size() > 0 && v_o[g]) begin
                    check($sformatf("dut%0d_header", g), 64'(hdr_o[g]), 64'(q[0].hdr));
                    check($sformatf("dut%0d_data", g), data_o[g], q[0].data);
                    check($sformatf("dut%0d_last", g), 64'(last_o[g]), 64'(q[0].last));
                end
            end
        end
    end

    // 64->64 single-entry instance for the one-word boundary
    logic [B_MSG_W-1:0] b_mi;
    logic               b_v, b_yumi, b_ready, b_vo, b_last, b_lock;
    logic [HDR_W-1:0]   b_hdr;
    logic [63:0]        b_data;

    bp_me_lite_to_stream_buffered #(
        .paddr_width_p(PADDR), .payload_width_p(PAY),
        .in_data_width_p(64), .out_data_width_p(64),
        .master_p(1), .buffer_els_p(1)
    ) dut_b (
        .clk_i(clk), .reset_i(reset),
        .mem_i(b_mi), .mem_v_i(b_v), .mem_ready_o(b_ready),
        .mem_header_o(b_hdr), .mem_data_o(b_data), .mem_v_o(b_vo),
        .mem_yumi_i(b_yumi), .mem_last_o(b_last), .mem_lock_o(b_lock)
    );

    logic [PADDR-1:0] exp_addr  [8];
    int               exp_slice [8];

    initial begin
        logic [IN_W-1:0] d;
        int cnt_a, cnt_c, consumed, acc_at, gaps;
        bit done;

        for (int g = 0; g < 2; g++) begin
            m_i[g] = '0; v_i[g] = 1'b0; yumi[g] = 1'b0;
        end
        b_mi = '0; b_v = 1'b0; b_yumi = 1'b0;

        repeat (3) @(negedge clk);
        check("ready_in_reset", 64'(ready_o[0]), 64'd0);
        check("valid_in_reset", 64'(v_o[0]), 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(ready_o[0]), 64'd1);

        // One-word instance: single beat, last on the only beat
        b_v = 1'b1;
        b_mi = {64'hDEAD_BEEF_0123_4567, mk_hdr(4'd1, 3'd3, 40'h1000, 16'h0)};
        check("b_no_bypass", 64'(b_vo), 64'd0);
        @(negedge clk);
        b_v = 1'b0;
        check("b_valid", 64'(b_vo), 64'd1);
        check("b_addr", 64'(b_hdr[4 +: PADDR]), 64'h1000);
        check("b_data", b_data, 64'hDEAD_BEEF_0123_4567);
        check("b_last", 64'(b_last), 64'd1);
        check("b_lock", 64'(b_lock), 64'd1);
        check("b_full_ready", 64'(b_ready), 64'd0);
        b_yumi = 1'b1;
        @(negedge clk);
        b_yumi = 1'b0;
        check("b_drained", 64'(b_vo), 64'd0);
        check("b_ready_back", 64'(b_ready), 64'd1);
        b_v = 1'b1;
        b_mi = {64'h0BAD_F00D_0000_0001, mk_hdr(4'd1, 3'd6, 40'h1040, 16'h0)};
        @(negedge clk);
        b_v = 1'b0;
        check("b_clamp_last", 64'(b_last), 64'd1);
        check("b_clamp_addr", 64'(b_hdr[4 +: PADDR]), 64'h1040);
        b_yumi = 1'b1;
        @(negedge clk);
        b_yumi = 1'b0;
        check("b_clamp_drained", 64'(b_vo), 64'd0);

        // 64B write at 0x2028, literal beat order
`ifdef BP_ME_LITE_TO_STREAM_WRAP_EN
        exp_addr  = '{40'h2028, 40'h2030, 40'h2038, 40'h2000, 40'h2008, 40'h2010, 40'h2018, 40'h2020};
        exp_slice = '{5, 6, 7, 0, 1, 2, 3, 4};
`else
        for (int i = 0; i < 8; i++) begin
            exp_addr[i]  = PADDR'(40'h2028 + 8 * i);
            exp_slice[i] = i;
        end
`endif
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'h1111_0000_0000_0000 | 64'(i);
        v_i[0] = 1'b1;
        m_i[0] = mk_msg(4'd1, 3'd6, 40'h2028, d);
        @(negedge clk);
        v_i[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr8_valid_%0d", i), 64'(v_o[0]), 64'd1);
            check($sformatf("wr8_addr_%0d", i), 64'(hdr_o[0][4 +: PADDR]), 64'(exp_addr[i]));
            check($sformatf("wr8_data_%0d", i), data_o[0], 64'h1111_0000_0000_0000 | 64'(exp_slice[i]));
            check($sformatf("wr8_last_%0d", i), 64'(last_o[0]), 64'(i == 7));
            yumi[0] = 1'b1;
            @(negedge clk);
        end
        yumi[0] = 1'b0;
        check("wr8_empty", 64'(v_o[0]), 64'd0);

        // 64B read: one beat in command direction, eight in response direction
        for (int g = 0; g < 2; g++) begin
            v_i[g] = 1'b1;
            m_i[g] = mk_msg(4'd0, 3'd6, 40'h6000, rand_data());
        end
        cnt_a = 0; cnt_c = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            v_i[0] = 1'b0; v_i[1] = 1'b0;
            if (v_o[0]) cnt_a++;
            if (v_o[1]) cnt_c++;
            yumi[0] = v_o[0]; yumi[1] = v_o[1];
        end
        yumi[0] = 1'b0; yumi[1] = 1'b0;
        check("rd_cmd_beats", 64'(cnt_a), 64'd1);
        check("rd_resp_beats", 64'(cnt_c), 64'd8);

        // Buffer full, then back-to-back drain
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            v_i[0] = 1'b1;
            m_i[0] = mk_msg(4'd3, 3'd6, PADDR'(40'h5000 + m * 64), rand_data());
        end
        check("full_ready_low", 64'(ready_o[0]), 64'd0);
        @(negedge clk);
        check("full_still_low", 64'(ready_o[0]), 64'd0);
        consumed = 0; acc_at = -1; gaps = 0;
        for (int c = 0; c < 60 && consumed < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (acc_at >= 0) v_i[0] = 1'b0;
            if (v_i[0] && ready_o[0] && acc_at < 0) acc_at = consumed;
            if (!v_o[0]) gaps++;
            yumi[0] = v_o[0];
            if (v_o[0]) consumed++;
        end
        @(negedge clk);
        yumi[0] = 1'b0; v_i[0] = 1'b0;
        check("b2b_accept_point", 64'(acc_at), 64'd8);
        check("b2b_no_bubble", 64'(gaps), 64'd0);
        check("b2b_beats", 64'(consumed), 64'd24);
        check("b2b_empty", 64'(v_o[0]), 64'd0);

        // Reset in the middle of a message
        v_i[0] = 1'b1;
        m_i[0] = mk_msg(4'd1, 3'd6, 40'h3000, rand_data());
        @(negedge clk);
        v_i[0] = 1'b0;
        yumi[0] = 1'b1;
        repeat (3) @(negedge clk);
        yumi[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(v_o[0]), 64'd0);
        check("rst_last", 64'(last_o[0]), 64'd0);
        check("rst_lock", 64'(lock_o[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_back", 64'(ready_o[0]), 64'd1);
        v_i[0] = 1'b1;
        m_i[0] = mk_msg(4'd1, 3'd6, 40'h4000, rand_data());
        @(negedge clk);
        v_i[0] = 1'b0;
        check("rst_restart_addr", 64'(hdr_o[0][4 +: PADDR]), 64'h4000);
        check("rst_restart_last", 64'(last_o[0]), 64'd0);
        for (int c = 0; c < 8; c++) begin
            yumi[0] = v_o[0];
            @(negedge clk);
        end
        yumi[0] = 1'b0;

        // Randomized traffic on both 512->64 instances
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < 2; g++) begin
                v_i[g]  = ($urandom_range(0, 2) != 0);
                m_i[g]  = rand_msg();
                yumi[g] = v_o[g] & ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
        end

        // Drain, bounded
        v_i[0] = 1'b0; v_i[1] = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            yumi[0] = v_o[0]; yumi[1] = v_o[1];
            @(negedge clk);
            done = !v_o[0] && !v_o[1];
        end
        yumi[0] = 1'b0; yumi[1] = 1'b0;
        check("drain_done", 64'(done), 64'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
